// File: rtl/four_function_calculator.sv
// Push-button four-function calculator: sign-magnitude entry, two's-complement accumulator, sticky overflow.
// Add/sub finish one edge after the Equals edge; mul/div take W+1 edges; presses during a compute are dropped.
module four_function_calculator #(
  parameter int W = 11
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Equals,
  input  logic         Add,
  input  logic         Subtract,
  input  logic         Multiply,
  input  logic         Divide,
  input  logic [W-1:0] NumberSM,
  output logic [W-1:0] Result,
  output logic         Overflow
);

  localparam int CW = $clog2(W + 1);
  localparam logic [2*W-1:0] L_MAXP = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] L_MINM = L_MAXP + {{(2*W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_ADDSUB, S_MUL, S_DIV, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t          r_state;
  op_t             r_op;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_b;
  logic            r_ovf;
  logic [4:0]      r_prev;
  logic [W-2:0]    r_b_mag;
  logic            r_sign;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_prod;
  logic [2*W-1:0]  r_mcand;
  logic [W-1:0]    r_mplier;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_quo;

  logic [4:0]      w_btn;
  logic [4:0]      w_press;
  logic            w_eq_p;
  logic            w_op_p;
  op_t             w_op_sel;
  logic            w_num_neg;
  logic [W-1:0]    w_num_tc;
  logic [W-1:0]    w_acc_mag;
  logic [W:0]      w_sum;
  logic            w_sum_ovf;
  logic [W-1:0]    w_rem_sh;
  logic            w_rem_ge;
  logic [2*W-1:0]  w_mag;
  logic [W-1:0]    w_md_res;
  logic            w_md_err;

  assign w_btn   = {Equals, Add, Subtract, Multiply, Divide};
  assign w_press = w_btn & ~r_prev;
  assign w_eq_p  = w_press[4];
  assign w_op_p  = |w_press[3:0];

  always_comb begin
    w_op_sel = OP_DIV;
    if (w_press[3])      w_op_sel = OP_ADD;
    else if (w_press[2]) w_op_sel = OP_SUB;
    else if (w_press[1]) w_op_sel = OP_MUL;
  end

  // Negative zero has an all-zero magnitude, so negation already yields 0.
  assign w_num_neg = NumberSM[W-1] & (|NumberSM[W-2:0]);
  assign w_num_tc  = NumberSM[W-1] ? -{1'b0, NumberSM[W-2:0]} : {1'b0, NumberSM[W-2:0]};
  assign w_acc_mag = r_acc[W-1] ? -r_acc : r_acc;

  assign w_sum     = (r_op == OP_SUB) ? ({r_acc[W-1], r_acc} - {r_b[W-1], r_b})
                                      : ({r_acc[W-1], r_acc} + {r_b[W-1], r_b});
  assign w_sum_ovf = w_sum[W] ^ w_sum[W-1];

  assign w_rem_sh  = {r_rem[W-2:0], r_quo[W-1]};
  assign w_rem_ge  = r_rem[W-1] | (w_rem_sh >= {1'b0, r_b_mag});

  assign w_mag     = (r_state == S_MUL) ? r_prod : {{W{1'b0}}, r_quo};
  assign w_md_res  = r_sign ? -w_mag[W-1:0] : w_mag[W-1:0];
  // A negative result may reach one past the positive limit (-2^(W-1)).
  assign w_md_err  = ((r_state == S_DIV) && (r_b_mag == '0)) ||
                     ((w_mag > L_MAXP) && !(r_sign && (w_mag == L_MINM)));

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_acc    <= '0;
      r_b      <= '0;
      r_ovf    <= 1'b0;
      r_prev   <= '0;
      r_b_mag  <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else begin
      r_prev <= w_btn;
      case (r_state)
        S_IDLE: begin
          if (w_eq_p) begin
            r_acc <= w_num_tc;
          end else if (w_op_p) begin
            r_op    <= w_op_sel;
            r_state <= S_PEND;
          end
        end
        S_PEND: begin
          if (w_eq_p) begin
            r_b      <= w_num_tc;
            r_b_mag  <= NumberSM[W-2:0];
            r_sign   <= r_acc[W-1] ^ w_num_neg;
            r_prod   <= '0;
            r_mcand  <= {{W{1'b0}}, w_acc_mag};
            r_mplier <= {1'b0, NumberSM[W-2:0]};
            r_rem    <= '0;
            r_quo    <= w_acc_mag;
            r_cnt    <= CW'(W);
            case (r_op)
              OP_MUL:  r_state <= S_MUL;
              OP_DIV:  r_state <= S_DIV;
              default: r_state <= S_ADDSUB;
            endcase
          end else if (w_op_p) begin
            r_op <= w_op_sel;
          end
        end
        S_ADDSUB: begin
          r_acc   <= w_sum[W-1:0];
          r_ovf   <= w_sum_ovf;
          r_state <= w_sum_ovf ? S_ERR : S_IDLE;
        end
        S_MUL, S_DIV: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_state == S_MUL) begin
              if (r_mplier[0]) r_prod <= r_prod + r_mcand;
              r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
              r_mplier <= {1'b0, r_mplier[W-1:1]};
            end else begin
              r_rem <= w_rem_ge ? (w_rem_sh - {1'b0, r_b_mag}) : w_rem_sh;
              r_quo <= {r_quo[W-2:0], w_rem_ge};
            end
          end else if (w_md_err) begin
            r_acc   <= '0;
            r_ovf   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_acc   <= w_md_res;
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Result   = r_acc;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_four_function_calculator.sv
// Directed-vector bench for four_function_calculator with hand-computed expected values (W=11).
module tb_four_function_calculator;
  localparam int W = 11;

  logic         Clock = 1'b0;
  logic         Clear = 1'b1;
  logic         Equals = 1'b0;
  logic         Add = 1'b0;
  logic         Subtract = 1'b0;
  logic         Multiply = 1'b0;
  logic         Divide = 1'b0;
  logic [W-1:0] NumberSM = '0;
  logic [W-1:0] Result;
  logic         Overflow;

  int n_checks = 0;
  int n_errors = 0;

  four_function_calculator #(.W(W)) dut (
    .Clock(Clock), .Clear(Clear), .Equals(Equals), .Add(Add), .Subtract(Subtract),
    .Multiply(Multiply), .Divide(Divide), .NumberSM(NumberSM), .Result(Result), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tick();
  endtask

  task automatic eq(input logic [W-1:0] n);
    NumberSM = n;
    Equals = 1'b1;
    tick();
    Equals = 1'b0;
    tick();
  endtask

  // mask order: {Add, Subtract, Multiply, Divide}
  task automatic ops(input logic [3:0] m);
    {Add, Subtract, Multiply, Divide} = m;
    tick();
    {Add, Subtract, Multiply, Divide} = 4'b0000;
    tick();
  endtask

  task automatic settle();
    repeat (W + 2) tick();
  endtask

  initial begin
    #1;
    check("reset_result", Result, 11'd0);
    check("reset_ovf", {10'd0, Overflow}, 11'd0);
    tick();
    Clear = 1'b0;
    tick();

    // 1 + 2
    do_clear(); eq(11'd1); ops(4'b1000); eq(11'd2); settle();
    check("add_1_2", Result, 11'd3);
    check("add_1_2_ovf", {10'd0, Overflow}, 11'd0);

    // 1 + 3 checked right after the second edge, then chained - 4
    do_clear(); eq(11'd1); ops(4'b1000); eq(11'd3);
    check("add_latency", Result, 11'd4);
    ops(4'b0100); eq(11'd4); settle();
    check("chain_sub", Result, 11'd0);

    // 1023 + (-1023)
    do_clear(); eq(11'd1023); ops(4'b1000); eq(11'h7FF); settle();
    check("add_pm1023", Result, 11'd0);
    check("add_pm1023_ovf", {10'd0, Overflow}, 11'd0);

    // 1023 + 10 wraps to -1015
    do_clear(); eq(11'd1023); ops(4'b1000); eq(11'd10); settle();
    check("add_ovf_res", Result, 11'd1033);
    check("add_ovf_flag", {10'd0, Overflow}, 11'd1);
    ops(4'b1000); eq(11'd1); settle();
    check("err_sticky_res", Result, 11'd1033);
    check("err_sticky_ovf", {10'd0, Overflow}, 11'd1);

    // 7 * -6 = -42, checked W+2 edges after Equals
    do_clear(); eq(11'd7); ops(4'b0010); eq(11'd1030);
    repeat (W) tick();
    check("mul_neg", Result, 11'd2006);
    check("mul_neg_ovf", {10'd0, Overflow}, 11'd0);

    // 1023 * 2 overflows
    do_clear(); eq(11'd1023); ops(4'b0010); eq(11'd2); settle();
    check("mul_ovf_flag", {10'd0, Overflow}, 11'd1);
    check("mul_ovf_res", Result, 11'd0);

    // -100 / 7 = -14
    do_clear(); eq(11'd1124); ops(4'b0001); eq(11'd7); settle();
    check("div_neg", Result, 11'd2034);

    // 5 / 0
    do_clear(); eq(11'd5); ops(4'b0001); eq(11'd0); settle();
    check("div0_flag", {10'd0, Overflow}, 11'd1);
    check("div0_res", Result, 11'd0);

    // -1023 - 1 = -1024 is legal; then -1024 / -1 overflows
    do_clear(); eq(11'h7FF); ops(4'b0100); eq(11'd1); settle();
    check("min_value", Result, 11'd1024);
    check("min_value_ovf", {10'd0, Overflow}, 11'd0);
    ops(4'b0001); eq(11'h401); settle();
    check("min_div_m1_flag", {10'd0, Overflow}, 11'd1);
    check("min_div_m1_res", Result, 11'd0);

    // 10 - (-20) = 30, then chained * -3 = -90
    do_clear(); eq(11'd10); ops(4'b0100); eq(11'd1044); settle();
    check("sub_neg_b", Result, 11'd30);
    ops(4'b0010); eq(11'd1027); settle();
    check("chain_mul_negneg", Result, 11'd1958);

    // Clear mid-multiply
    do_clear(); eq(11'd3); ops(4'b0010); eq(11'd3);
    repeat (3) tick();
    #2 Clear = 1'b1;
    #1;
    check("midmul_clr_res", Result, 11'd0);
    check("midmul_clr_ovf", {10'd0, Overflow}, 11'd0);
    tick();
    Clear = 1'b0;
    tick();
    eq(11'd5);
    check("after_clr_idle", Result, 11'd5);

    // negative zero entry
    eq(11'd1024);
    check("neg_zero", Result, 11'd0);

    // Equals held five cycles counts once: 5 + 2
    do_clear(); eq(11'd5); ops(4'b1000);
    NumberSM = 11'd2;
    Equals = 1'b1;
    repeat (5) tick();
    Equals = 1'b0;
    settle();
    check("eq_held_once", Result, 11'd7);

    // Add beats Multiply when pressed together
    do_clear(); eq(11'd6); ops(4'b1010); eq(11'd3); settle();
    check("prio_add_mul", Result, 11'd9);

    // op replaced while pending
    do_clear(); eq(11'd6); ops(4'b1000); ops(4'b0100); eq(11'd2); settle();
    check("op_replace", Result, 11'd4);

    // Equals beats Add in IDLE: load 9, stay IDLE, next Equals loads 2
    do_clear(); eq(11'd6);
    NumberSM = 11'd9;
    Equals = 1'b1;
    Add = 1'b1;
    tick();
    Equals = 1'b0;
    Add = 1'b0;
    tick();
    check("prio_eq_load", Result, 11'd9);
    eq(11'd2); settle();
    check("prio_eq_idle", Result, 11'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end
endmodule

// File: doc/four_function_calculator.md
Name: four_function_calculator

Overview:
- Sequential four-function integer calculator (+, −, ×, ÷) for a board-level front end: push buttons plus a W-bit switch bank.
- Operands are entered in sign-magnitude and converted internally to two's complement by an embedded SM-to-TC converter.
- An accumulator holds the running result, shown on Result in two's complement; Overflow flags out-of-range results and errors.
- Add/subtract take one compute cycle; multiply and divide are iterative shift-based units that take W cycles.

Parameters:
- W, 11, data width of operand input, accumulator and Result.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Clear  input  1  reset, asynchronous, active-high (the C button).
- Equals  input  1  enter/equals button, level; acted on at its rising edge.
- Add  input  1  + button, level; acted on at its rising edge.
- Subtract  input  1  − button, level; acted on at its rising edge.
- Multiply  input  1  × button, level; acted on at its rising edge.
- Divide  input  1  ÷ button, level; acted on at its rising edge.
- NumberSM  input  W  operand in sign-magnitude: bit W−1 is the sign, bits W−2:0 are the magnitude.
- Result  output  W  signed two's-complement accumulator value.
- Overflow  output  1  sticky error flag.

Behaviour:
- Clear=1, at any time including mid-multiply/divide:
  - Result=0, Overflow=0, accumulator=0, no pending op, state IDLE, button history registers=0.
- Button edge detection:
  - Each button has a registered previous value; press = button & ~prev, evaluated at a rising Clock edge.
  - A button held high for many cycles counts as a single press.
  - Simultaneous presses: Equals has priority over the operator buttons.
  - Among operator buttons the priority is Add > Subtract > Multiply > Divide.
- SM→TC conversion (combinational):
  - Sign=0 gives the magnitude zero-extended.
  - Sign=1 gives the negated magnitude.
  - Negative zero (1000…0) maps to 0. Input range is ±(2^(W−1)−1).
- States:
  - IDLE/DISPLAY:
    - Equals press: NumberSM (converted) is sampled at that edge and loaded into the accumulator; Result shows it after the same edge.
    - Operator press: stores the op and goes to PENDING; Result keeps showing the accumulator.
  - PENDING:
    - Another operator press replaces the stored op.
    - Equals press: samples NumberSM as operand B; Add/Sub go to ADDSUB, Mul goes to MUL, Div goes to DIV.
  - ADDSUB:
    - One cycle: accumulator = acc ± B, then back to DISPLAY.
    - Result is valid after the second rising edge counted from the Equals-detect edge.
  - MUL:
    - W-cycle shift-add on magnitudes; sign is the XOR of the operand signs; then back to DISPLAY.
    - Result is valid no later than W+2 edges after Equals detect.
  - DIV:
    - W-cycle restoring division on magnitudes; quotient truncates toward zero; remainder is discarded; sign is the XOR of the operand signs.
    - Same latency bound as MUL.
  - ERROR: entered when Overflow is set.
- Button presses while in ADDSUB, MUL or DIV are ignored, and are not queued.
- Chaining: after a result is shown, an operator press uses Result as the left operand (1+3−4 works without re-entry).
- Overflow conditions:
  - The true result lies outside [−2^(W−1), 2^(W−1)−1].
  - Divide by zero.
  - −2^(W−1) ÷ −1.
- On overflow:
  - Overflow=1.
  - Result = low W bits of the true sum/difference for add/sub, and 0 for mul/div errors.
  - State goes to ERROR; all buttons are ignored until Clear.
- The accumulator may reach −2^(W−1) through arithmetic, for example −1023−1 with W=11; this is legal and is not an overflow.

Test Plan:
- Clear; Equals with NumberSM=1; Add; Equals with NumberSM=2 → Result=3, Overflow=0.
- Clear; 1, Add, 3, Equals → 4; then Subtract, Equals with NumberSM=4 → Result=0.
- Clear; 1023, Add, then 11'b11111111111 (−1023) → Result=0, Overflow=0. Repeat with 1023 + 10 → Overflow=1 and Result=−1015 (wrapped); a later Add press leaves both unchanged.
- Clear; 7, Multiply, then −6 (sign bit + 6) → Result=−42 within W+2 cycles. Then 1023 × 2 → Overflow=1.
- Clear; −100, Divide, 7 → Result=−14. Then a fresh Clear; 5, Divide, 0 → Overflow=1, Result=0.
- Clear asserted mid-multiply: Result=0, Overflow=0, state IDLE immediately. Negative-zero entry → Result=0. Equals held high for 5 cycles → a single load only.
